// File: rtl/alu_issue.sv
// alu_issue: ID/EX pipeline register that issues decoded instructions to the ALU.
// One entry deep with registered outputs, so an accepted instruction appears on
// the outputs one cycle later. Operands are resolved here, including the
// optional EX/MEM and MEM/WB forwarding.
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_id_valid / o_id_ready      handshake with the decode stage
//   i_pc, i_rs1_data, i_rs2_data, i_imm   PC, register-file reads, immediate
//   i_rs1_addr, i_rs2_addr, i_rd_addr, i_opcode, i_funct3, i_funct7_5  decoded fields
//   i_exm_wr_en/_rd/_data        EX/MEM forward source
//   i_wb_wr_en/_rd/_data         MEM/WB forward source
//   i_flush, i_ex_ready          kill the stage contents / execute stage accepts
//   o_ex_valid, o_op1, o_op2, o_alu_ctrl, o_rd_addr, o_rd_wr_en,
//   o_is_branch, o_branch_inv, o_illegal   issued instruction to execute
module alu_issue #(
    parameter bit FWD_EN = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_id_valid,
    output logic        o_id_ready,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_rs1_data,
    input  logic [31:0] i_rs2_data,
    input  logic [31:0] i_imm,
    input  logic [4:0]  i_rs1_addr,
    input  logic [4:0]  i_rs2_addr,
    input  logic [4:0]  i_rd_addr,
    input  logic [6:0]  i_opcode,
    input  logic [2:0]  i_funct3,
    input  logic        i_funct7_5,
    input  logic        i_exm_wr_en,
    input  logic [4:0]  i_exm_rd,
    input  logic [31:0] i_exm_data,
    input  logic        i_wb_wr_en,
    input  logic [4:0]  i_wb_rd,
    input  logic [31:0] i_wb_data,
    input  logic        i_flush,
    input  logic        i_ex_ready,
    output logic        o_ex_valid,
    output logic [31:0] o_op1,
    output logic [31:0] o_op2,
    output logic [3:0]  o_alu_ctrl,
    output logic [4:0]  o_rd_addr,
    output logic        o_rd_wr_en,
    output logic        o_is_branch,
    output logic        o_branch_inv,
    output logic        o_illegal
);

    // ALU control codes shared with the execute stage.
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_BUF  = 4'd10;
    localparam logic [3:0] ALU_EQ   = 4'd11;
    localparam logic [3:0] ALU_GE   = 4'd12;
    localparam logic [3:0] ALU_GEU  = 4'd13;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    logic        ex_valid_q, ex_valid_d;
    logic [31:0] op1_q, op1_d;
    logic [31:0] op2_q, op2_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [4:0]  rd_q;
    logic        wr_q, wr_d;
    logic        br_q, br_d;
    logic        inv_q, inv_d;
    logic        ill_q, ill_d;

    logic [31:0] rs1_fwd, rs2_fwd;
    logic [3:0]  arith_ctrl;
    logic        accept;

    // EX/MEM is the younger result, so it is checked before MEM/WB.
    function automatic logic [31:0] resolve(input logic [4:0] addr, input logic [31:0] rf_data);
        logic [31:0] val;
        val = rf_data;
        if (addr == 5'd0) begin
            val = 32'd0;
        end else if (FWD_EN && i_exm_wr_en && (i_exm_rd == addr)) begin
            val = i_exm_data;
        end else if (FWD_EN && i_wb_wr_en && (i_wb_rd == addr)) begin
            val = i_wb_data;
        end
        return val;
    endfunction

    always_comb begin
        rs1_fwd = resolve(i_rs1_addr, i_rs1_data);
        rs2_fwd = resolve(i_rs2_addr, i_rs2_data);
    end

    // funct7_5 turns ADD into SUB only for register-register ops; immediate
    // ops carry immediate bits there except for the shift-right encoding.
    always_comb begin
        arith_ctrl = ALU_ADD;
        case (i_funct3)
            3'b000: arith_ctrl = (i_funct7_5 && i_opcode == OPC_OP) ? ALU_SUB : ALU_ADD;
            3'b001: arith_ctrl = ALU_SLL;
            3'b010: arith_ctrl = ALU_SLT;
            3'b011: arith_ctrl = ALU_SLTU;
            3'b100: arith_ctrl = ALU_XOR;
            3'b101: arith_ctrl = i_funct7_5 ? ALU_SRA : ALU_SRL;
            3'b110: arith_ctrl = ALU_OR;
            3'b111: arith_ctrl = ALU_AND;
            default: arith_ctrl = ALU_ADD;
        endcase
    end

    always_comb begin
        ctrl_d = ALU_ADD;
        op1_d  = 32'd0;
        op2_d  = 32'd0;
        wr_d   = 1'b0;
        br_d   = 1'b0;
        inv_d  = 1'b0;
        ill_d  = 1'b0;
        case (i_opcode)
            OPC_OP: begin
                ctrl_d = arith_ctrl; op1_d = rs1_fwd; op2_d = rs2_fwd; wr_d = 1'b1;
            end
            OPC_OPIMM: begin
                ctrl_d = arith_ctrl; op1_d = rs1_fwd; op2_d = i_imm; wr_d = 1'b1;
            end
            OPC_LUI: begin
                ctrl_d = ALU_BUF; op2_d = i_imm; wr_d = 1'b1;
            end
            OPC_AUIPC: begin
                op1_d = i_pc; op2_d = i_imm; wr_d = 1'b1;
            end
            OPC_LOAD, OPC_STORE: begin
                op1_d = rs1_fwd; op2_d = i_imm; wr_d = (i_opcode == OPC_LOAD);
            end
            OPC_JAL, OPC_JALR: begin
                op1_d = i_pc; op2_d = 32'd4; wr_d = 1'b1;
            end
            OPC_BRANCH: begin
                if (i_funct3 == 3'b010 || i_funct3 == 3'b011) begin
                    ill_d = 1'b1;
                end else begin
                    op1_d = rs1_fwd;
                    op2_d = rs2_fwd;
                    br_d  = 1'b1;
                    case (i_funct3)
                        3'b000:  ctrl_d = ALU_EQ;
                        3'b001:  begin ctrl_d = ALU_EQ; inv_d = 1'b1; end
                        3'b100:  ctrl_d = ALU_SLT;
                        3'b101:  ctrl_d = ALU_GE;
                        3'b110:  ctrl_d = ALU_SLTU;
                        default: ctrl_d = ALU_GEU;
                    endcase
                end
            end
            default: ill_d = 1'b1;
        endcase
        if (i_rd_addr == 5'd0) begin
            wr_d = 1'b0;
        end
    end

    assign o_id_ready = !ex_valid_q | i_ex_ready;
    assign accept     = i_id_valid & o_id_ready & !i_flush;

    always_comb begin
        ex_valid_d = ex_valid_q;
        if (i_flush) begin
            ex_valid_d = 1'b0;
        end else if (accept) begin
            ex_valid_d = 1'b1;
        end else if (i_ex_ready) begin
            ex_valid_d = 1'b0;
        end
    end

    // Payload only loads on accept, so a stalled entry stays put.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ex_valid_q <= 1'b0;
            op1_q      <= 32'd0;
            op2_q      <= 32'd0;
            ctrl_q     <= 4'd0;
            rd_q       <= 5'd0;
            wr_q       <= 1'b0;
            br_q       <= 1'b0;
            inv_q      <= 1'b0;
            ill_q      <= 1'b0;
        end else begin
            ex_valid_q <= ex_valid_d;
            if (accept) begin
                op1_q  <= op1_d;
                op2_q  <= op2_d;
                ctrl_q <= ctrl_d;
                rd_q   <= i_rd_addr;
                wr_q   <= wr_d;
                br_q   <= br_d;
                inv_q  <= inv_d;
                ill_q  <= ill_d;
            end
        end
    end

    assign o_ex_valid   = ex_valid_q;
    assign o_op1        = op1_q;
    assign o_op2        = op2_q;
    assign o_alu_ctrl   = ctrl_q;
    assign o_rd_addr    = rd_q;
    assign o_rd_wr_en   = wr_q;
    assign o_is_branch  = br_q;
    assign o_branch_inv = inv_q;
    assign o_illegal    = ill_q;

endmodule

// File: tb/tb_alu_issue.sv
module tb_alu_issue;

    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, SLL = 4'd2, SLT = 4'd3, SLTU = 4'd4,
                           XOR = 4'd5, SRL = 4'd6, SRA = 4'd7, OR = 4'd8, AND = 4'd9,
                           BUF = 4'd10, EQ = 4'd11, GE = 4'd12, GEU = 4'd13;
    localparam logic [3:0] R_TAB [0:7] = '{ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND};
    localparam logic [3:0] B_TAB [0:7] = '{EQ, EQ, ADD, ADD, SLT, GE, SLTU, GEU};
    localparam logic [6:0] OPS [0:11] = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111,
                                           7'b0000011, 7'b0100011, 7'b1101111, 7'b1100111,
                                           7'b1100011, 7'b1100011, 7'b1111111, 7'b0001111};

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic        wr;
        logic        br;
        logic        inv;
        logic        ill;
    } exp_t;

    logic        i_clk = 1'b0;
    logic        i_rst, i_id_valid, i_funct7_5, i_exm_wr_en, i_wb_wr_en, i_flush, i_ex_ready;
    logic [31:0] i_pc, i_rs1_data, i_rs2_data, i_imm, i_exm_data, i_wb_data;
    logic [4:0]  i_rs1_addr, i_rs2_addr, i_rd_addr, i_exm_rd, i_wb_rd;
    logic [6:0]  i_opcode;
    logic [2:0]  i_funct3;

    logic        f_ready, f_valid, f_wr, f_br, f_inv, f_ill;
    logic [31:0] f_op1, f_op2;
    logic [3:0]  f_ctrl;
    logic [4:0]  f_rd;
    logic        n_ready, n_valid, n_wr, n_br, n_inv, n_ill;
    logic [31:0] n_op1, n_op2;
    logic [3:0]  n_ctrl;
    logic [4:0]  n_rd;

    int   vectors = 0;
    int   miscompares = 0;
    bit   m_valid = 1'b0;
    bit   m_show = 1'b0;
    exp_t m_f, m_n;

    always #5 i_clk = ~i_clk;

    alu_issue #(.FWD_EN(1'b1)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_id_valid(i_id_valid), .o_id_ready(f_ready),
        .i_pc(i_pc), .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_imm(i_imm),
        .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr), .i_rd_addr(i_rd_addr),
        .i_opcode(i_opcode), .i_funct3(i_funct3), .i_funct7_5(i_funct7_5),
        .i_exm_wr_en(i_exm_wr_en), .i_exm_rd(i_exm_rd), .i_exm_data(i_exm_data),
        .i_wb_wr_en(i_wb_wr_en), .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data),
        .i_flush(i_flush), .i_ex_ready(i_ex_ready), .o_ex_valid(f_valid),
        .o_op1(f_op1), .o_op2(f_op2), .o_alu_ctrl(f_ctrl), .o_rd_addr(f_rd),
        .o_rd_wr_en(f_wr), .o_is_branch(f_br), .o_branch_inv(f_inv), .o_illegal(f_ill));

    alu_issue #(.FWD_EN(1'b0)) dut_nf (
        .i_clk(i_clk), .i_rst(i_rst), .i_id_valid(i_id_valid), .o_id_ready(n_ready),
        .i_pc(i_pc), .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_imm(i_imm),
        .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr), .i_rd_addr(i_rd_addr),
        .i_opcode(i_opcode), .i_funct3(i_funct3), .i_funct7_5(i_funct7_5),
        .i_exm_wr_en(i_exm_wr_en), .i_exm_rd(i_exm_rd), .i_exm_data(i_exm_data),
        .i_wb_wr_en(i_wb_wr_en), .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data),
        .i_flush(i_flush), .i_ex_ready(i_ex_ready), .o_ex_valid(n_valid),
        .o_op1(n_op1), .o_op2(n_op2), .o_alu_ctrl(n_ctrl), .o_rd_addr(n_rd),
        .o_rd_wr_en(n_wr), .o_is_branch(n_br), .o_branch_inv(n_inv), .o_illegal(n_ill));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] operand(input logic [4:0] addr, input logic [31:0] rf, input bit fwd);
        if (addr == 0) return 32'd0;
        if (fwd && i_exm_wr_en && i_exm_rd == addr) return i_exm_data;
        if (fwd && i_wb_wr_en && i_wb_rd == addr) return i_wb_data;
        return rf;
    endfunction

    function automatic exp_t ref_decode(input bit fwd);
        exp_t e;
        logic [31:0] a, b;
        a = operand(i_rs1_addr, i_rs1_data, fwd);
        b = operand(i_rs2_addr, i_rs2_data, fwd);
        e = '0;
        e.ctrl = ADD;
        e.rd = i_rd_addr;
        if (i_opcode == 7'b0110011) begin
            e.op1 = a; e.op2 = b; e.wr = 1;
            e.ctrl = R_TAB[i_funct3];
            if (i_funct7_5 && i_funct3 == 0) e.ctrl = SUB;
            if (i_funct7_5 && i_funct3 == 5) e.ctrl = SRA;
        end else if (i_opcode == 7'b0010011) begin
            e.op1 = a; e.op2 = i_imm; e.wr = 1;
            e.ctrl = (i_funct7_5 && i_funct3 == 5) ? SRA : R_TAB[i_funct3];
        end else if (i_opcode == 7'b0110111) begin
            e.ctrl = BUF; e.op2 = i_imm; e.wr = 1;
        end else if (i_opcode == 7'b0010111) begin
            e.op1 = i_pc; e.op2 = i_imm; e.wr = 1;
        end else if (i_opcode == 7'b0000011 || i_opcode == 7'b0100011) begin
            e.op1 = a; e.op2 = i_imm; e.wr = (i_opcode == 7'b0000011);
        end else if (i_opcode == 7'b1101111 || i_opcode == 7'b1100111) begin
            e.op1 = i_pc; e.op2 = 4; e.wr = 1;
        end else if (i_opcode == 7'b1100011 && i_funct3 != 2 && i_funct3 != 3) begin
            e.op1 = a; e.op2 = b; e.br = 1;
            e.ctrl = B_TAB[i_funct3];
            e.inv = (i_funct3 == 1);
        end else begin
            e.ill = 1;
        end
        if (i_rd_addr == 0) e.wr = 0;
        return e;
    endfunction

    task automatic chk_payload(input string who, input exp_t e, input logic [31:0] op1,
                               input logic [31:0] op2, input logic [3:0] ctrl, input logic [4:0] rd,
                               input logic wr, input logic br, input logic inv, input logic ill);
        chk({who, "_op1"}, op1, e.op1);
        chk({who, "_op2"}, op2, e.op2);
        chk({who, "_ctrl"}, 32'(ctrl), 32'(e.ctrl));
        chk({who, "_rd"}, 32'(rd), 32'(e.rd));
        chk({who, "_wr"}, 32'(wr), 32'(e.wr));
        chk({who, "_br"}, 32'(br), 32'(e.br));
        chk({who, "_inv"}, 32'(inv), 32'(e.inv));
        chk({who, "_ill"}, 32'(ill), 32'(e.ill));
    endtask

    // One clock: check ready, advance the reference, clock, check outputs.
    task automatic cycle();
        bit acc;
        #1;
        chk("id_ready", 32'(f_ready), 32'(!m_valid || i_ex_ready));
        chk("id_ready_nf", 32'(n_ready), 32'(!m_valid || i_ex_ready));
        acc = i_id_valid && (!m_valid || i_ex_ready) && !i_flush;
        m_show = 0;
        if (i_rst) begin
            m_valid = 0; m_f = '0; m_n = '0; m_show = 1;
        end else if (i_flush) begin
            m_valid = 0;
        end else if (acc) begin
            m_valid = 1; m_f = ref_decode(1); m_n = ref_decode(0);
        end else if (i_ex_ready) begin
            m_valid = 0;
        end
        @(posedge i_clk);
        #1;
        chk("ex_valid", 32'(f_valid), 32'(m_valid));
        chk("ex_valid_nf", 32'(n_valid), 32'(m_valid));
        if (m_valid || m_show) begin
            chk_payload("fwd", m_f, f_op1, f_op2, f_ctrl, f_rd, f_wr, f_br, f_inv, f_ill);
            chk_payload("nofwd", m_n, n_op1, n_op2, n_ctrl, n_rd, n_wr, n_br, n_inv, n_ill);
        end
    endtask

    task automatic idle();
        i_rst = 0; i_id_valid = 0; i_flush = 0; i_ex_ready = 1;
        i_exm_wr_en = 0; i_wb_wr_en = 0; i_exm_rd = 0; i_wb_rd = 0;
        i_exm_data = 0; i_wb_data = 0;
    endtask

    task automatic instr(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm);
        i_opcode = opc; i_funct3 = f3; i_funct7_5 = f7;
        i_rs1_addr = rs1; i_rs2_addr = rs2; i_rd_addr = rd;
        i_rs1_data = d1; i_rs2_data = d2; i_imm = imm; i_pc = 32'h0000_1000;
    endtask

    initial begin
        idle();
        instr(7'b0110011, 0, 0, 1, 2, 3, 5, 7, 0);
        i_rst = 1;
        cycle();
        cycle();
        chk("rst_valid", 32'(f_valid), 0);
        chk("rst_ctrl", 32'(f_ctrl), 0);
        i_rst = 0;

        // ADD x3,x1,x2
        i_id_valid = 1;
        cycle();
        chk("add_op1", f_op1, 5);
        chk("add_op2", f_op2, 7);
        chk("add_rd", 32'(f_rd), 3);

        // both forward sources hit rs1: EX/MEM wins, disabled instance sees rf
        i_exm_wr_en = 1; i_exm_rd = 1; i_exm_data = 100;
        i_wb_wr_en = 1; i_wb_rd = 1; i_wb_data = 200;
        cycle();
        chk("fwd_op1", f_op1, 100);
        chk("nofwd_op1", n_op1, 5);
        idle();

        // stall three cycles with a new instruction waiting
        i_id_valid = 1;
        i_ex_ready = 0;
        instr(7'b0110011, 3'b100, 0, 4, 5, 6, 32'h11, 32'h22, 0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("stall_ready", 32'(f_ready), 0);
            chk("stall_op1", f_op1, 100);
        end
        i_ex_ready = 1;
        cycle();
        chk("release_op1", f_op1, 32'h11);
        chk("release_ctrl", 32'(f_ctrl), 32'(XOR));

        // flush beats accept
        i_flush = 1;
        cycle();
        chk("flush_valid", 32'(f_valid), 0);
        i_flush = 0;

        // reset mid-stall
        cycle();
        i_ex_ready = 0;
        cycle();
        i_rst = 1;
        cycle();
        chk("rst_stall_valid", 32'(f_valid), 0);
        chk("rst_stall_op1", f_op1, 0);
        idle();

        // BNE and illegal opcode
        i_id_valid = 1;
        instr(7'b1100011, 3'b001, 0, 1, 2, 9, 3, 4, 0);
        cycle();
        chk("bne_ctrl", 32'(f_ctrl), 32'(EQ));
        chk("bne_inv", 32'(f_inv), 1);
        chk("bne_wr", 32'(f_wr), 0);
        instr(7'b1111111, 0, 0, 1, 2, 9, 3, 4, 0);
        cycle();
        chk("ill_flag", 32'(f_ill), 1);
        chk("ill_wr", 32'(f_wr), 0);

        // SRAI and ADDI x0,x0,1
        instr(7'b0010011, 3'b101, 1, 1, 0, 7, 32'h8000_0000, 0, 4);
        cycle();
        chk("srai_ctrl", 32'(f_ctrl), 32'(SRA));
        chk("srai_op2", f_op2, 4);
        instr(7'b0010011, 3'b000, 0, 0, 0, 0, 32'h55, 0, 1);
        cycle();
        chk("addi_x0_op1", f_op1, 0);
        chk("addi_x0_wr", 32'(f_wr), 0);

        // randomized traffic
        for (int n = 0; n < 800; n++) begin
            i_rst       = ($urandom_range(0, 63) == 0);
            i_flush     = ($urandom_range(0, 15) == 0);
            i_id_valid  = ($urandom_range(0, 3) != 0);
            i_ex_ready  = ($urandom_range(0, 2) != 0);
            i_opcode    = OPS[$urandom_range(0, 11)];
            if ($urandom_range(0, 15) == 0) i_opcode = 7'($urandom);
            i_funct3    = 3'($urandom);
            i_funct7_5  = 1'($urandom);
            i_rs1_addr  = 5'($urandom_range(0, 3));
            i_rs2_addr  = 5'($urandom_range(0, 3));
            i_rd_addr   = 5'($urandom_range(0, 3));
            i_rs1_data  = $urandom;
            i_rs2_data  = $urandom;
            i_imm       = $urandom;
            i_pc        = $urandom;
            i_exm_wr_en = 1'($urandom);
            i_exm_rd    = 5'($urandom_range(0, 3));
            i_exm_data  = $urandom;
            i_wb_wr_en  = 1'($urandom);
            i_wb_rd     = 5'($urandom_range(0, 3));
            i_wb_data   = $urandom;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter FWD_EN, default 1, meaning: 1 enables EX/MEM and MEM/WB operand forwarding; 0 uses register-file data only.
REQ-002 One clock; reset is synchronous and active-high. i_clk input 1 is the rising-edge clock, and i_rst input 1 is the synchronous active-high reset.
REQ-003 i_id_valid input 1, decoded instruction valid; o_id_ready output 1, stage can accept.
REQ-004 i_pc, i_rs1_data, i_rs2_data, i_imm inputs 32 each: PC, register-file reads and sign-extended immediate.
REQ-005 i_rs1_addr, i_rs2_addr, i_rd_addr inputs 5 each; i_opcode input 7; i_funct3 input 3; i_funct7_5 input 1 (instr[30]).
REQ-006 i_exm_wr_en input 1, i_exm_rd input 5, i_exm_data input 32: EX/MEM writeback forward source.
REQ-007 i_wb_wr_en input 1, i_wb_rd input 5, i_wb_data input 32: MEM/WB forward source.
REQ-008 i_flush input 1, kill stage contents; i_ex_ready input 1, execute stage accepts.
REQ-009 o_ex_valid output 1; o_op1, o_op2 outputs 32; o_alu_ctrl output 4, code from rtl/parameters.vh; o_rd_addr output 5; o_rd_wr_en output 1.
REQ-010 o_is_branch output 1; o_branch_inv output 1, branch taken on ALU result 0; o_illegal output 1.

Function
REQ-011 The block SHALL be the ID/EX register driving the ALU: one entry, registered outputs, 1-cycle latency from accept to o_ex_valid.
REQ-012 o_id_ready SHALL equal !o_ex_valid | i_ex_ready, combinationally.
REQ-013 Accept SHALL occur when i_id_valid & o_id_ready & !i_flush; all outputs load at that edge.
REQ-014 o_ex_valid next: 0 if i_flush; else 1 if accept; else 0 if i_ex_ready; else hold.
REQ-015 While o_ex_valid & !i_ex_ready, all outputs SHALL hold stable.
REQ-016 i_flush SHALL take priority over a simultaneous accept and over holding; outputs other than o_ex_valid may keep stale values.
REQ-017 Forwarded operand rsN: 0 if rsN_addr==0; else i_exm_data if FWD_EN & i_exm_wr_en & i_exm_rd==rsN_addr; else i_wb_data if FWD_EN & i_wb_wr_en & i_wb_rd==rsN_addr; else i_rsN_data. EX/MEM wins over MEM/WB.
REQ-018 OP (0110011): op1=rs1, op2=rs2; funct3 000 ADD (SUB if funct7_5), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL (SRA if funct7_5), 110 OR, 111 AND; rd write 1.
REQ-019 OP-IMM (0010011): op1=rs1, op2=i_imm; same table except funct3 000 always ADD; funct7_5 selects SRA only for 101; rd write 1.
REQ-020 LUI (0110111): ctrl BUF, op2=i_imm, op1=0; AUIPC (0010111): ADD, op1=i_pc, op2=i_imm; rd write 1.
REQ-021 LOAD (0000011), STORE (0100011): ADD, op1=rs1, op2=i_imm; rd write 1 for LOAD, 0 for STORE.
REQ-022 JAL (1101111), JALR (1100111): ADD, op1=i_pc, op2=32'd4 (link address); rd write 1.
REQ-023 BRANCH (1100011): op1=rs1, op2=rs2, o_is_branch=1, rd write 0; 000 EQ inv0, 001 EQ inv1, 100 SLT inv0, 101 GE inv0, 110 SLTU inv0, 111 GEU inv0; 010/011 illegal.
REQ-024 Any other opcode/funct3: o_illegal=1, ctrl ADD, op1=op2=0, o_rd_wr_en=0, o_is_branch=0; o_ex_valid still asserts.
REQ-025 o_rd_wr_en SHALL be forced 0 when i_rd_addr==0.

Reset
REQ-026 With i_rst high at a rising edge, all outputs SHALL be 0 (o_ex_valid=0, o_alu_ctrl=0), and o_id_ready reads 1.
REQ-027 Reset SHALL override flush and accept; an entry held mid-stall is discarded.

Verification
REQ-028 ADD x3,x1,x2 with rs1_data=5, rs2_data=7, no forward -> next cycle o_ex_valid=1, op1=5, op2=7, ctrl=ADD, rd=3, wr_en=1.
REQ-029 Same, with i_exm_wr_en=1, exm_rd=1, exm_data=100 and i_wb_wr_en=1, wb_rd=1, wb_data=200 -> op1=100; with FWD_EN=0 -> op1=5.
REQ-030 Valid entry, i_ex_ready=0 for 3 cycles, new i_id_valid -> o_id_ready=0, outputs unchanged; i_ex_ready=1 -> new instruction loads next edge.
REQ-031 i_flush=1 with i_id_valid=1 -> o_ex_valid=0 next cycle; i_rst=1 mid-stall -> o_ex_valid=0, op1=op2=0.
REQ-032 BNE (funct3 001) -> ctrl=EQ, o_branch_inv=1, o_is_branch=1, wr_en=0; opcode 7'b1111111 -> o_illegal=1, wr_en=0.
REQ-033 SRAI with funct7_5=1, imm=4 -> ctrl=SRA, op2=4; ADDI x0,x0,1 -> op1=0, wr_en=0.
